// File: rtl/snn_lif_if.sv
// Control/parameter/spike bundle between spi_interface and the LIF layer.
// Master drives configuration and strobes; slave is the neuron core.
interface snn_lif_if #(
  parameter int WIDTH    = 16,
  parameter int N_INPUT  = 4,
  parameter int N_OUTPUT = 3
);
  localparam int SRCW = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;
  localparam int DSTW = (N_OUTPUT > 1) ? $clog2(N_OUTPUT) : 1;

  logic [WIDTH-1:0]        param_threshold;
  logic [WIDTH-1:0]        param_leak;
  logic [WIDTH-1:0]        param_refr;
  logic signed [WIDTH-1:0] param_vmax;
  logic signed [WIDTH-1:0] param_vmin;
  logic                    load_params;
  logic [SRCW-1:0]         syn_src;
  logic [DSTW-1:0]         syn_dst;
  logic signed [WIDTH-1:0] syn_weight;
  logic                    update_synapse;
  logic                    net_reset;
  logic [N_INPUT-1:0]      spike_in;
  logic                    step;
  logic                    busy;
  logic                    done;
  logic                    spike_out [N_OUTPUT];
  logic [DSTW-1:0]         dbg_sel;
  logic signed [WIDTH-1:0] dbg_vmem;

  modport master (
    output param_threshold, param_leak, param_refr,
    output param_vmax, param_vmin, load_params,
    output syn_src, syn_dst, syn_weight, update_synapse,
    output net_reset, spike_in, step, dbg_sel,
    input  busy, done, spike_out, dbg_vmem
  );

  modport slave (
    input  param_threshold, param_leak, param_refr,
    input  param_vmax, param_vmin, load_params,
    input  syn_src, syn_dst, syn_weight, update_synapse,
    input  net_reset, spike_in, step, dbg_sel,
    output busy, done, spike_out, dbg_vmem
  );
endinterface

// File: rtl/snn_lif_core.sv
// Leaky integrate-and-fire layer: one neuron evaluated per cycle,
// spike vector published atomically at the end of each time step.
module snn_lif_core #(
  parameter int WIDTH    = 16,
  parameter int N_INPUT  = 4,
  parameter int N_OUTPUT = 3
) (
  input  logic      clk,
  input  logic      reset,
  snn_lif_if.slave  bus
);
  localparam int SRCW = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;
  localparam int DSTW = (N_OUTPUT > 1) ? $clog2(N_OUTPUT) : 1;
  localparam int AW   = WIDTH + $clog2(N_INPUT) + 2;
  localparam logic [DSTW-1:0] LAST = DSTW'(N_OUTPUT - 1);

  typedef enum logic [1:0] {IDLE, EVAL, COMMIT} state_e;

  state_e state_q, state_d;

  logic signed [WIDTH-1:0] w_q [N_INPUT][N_OUTPUT];
  logic signed [WIDTH-1:0] v_q [N_OUTPUT];
  logic [WIDTH-1:0]        refr_q [N_OUTPUT];
  logic [N_OUTPUT-1:0]     shadow_q;
  logic [N_OUTPUT-1:0]     spike_q;
  logic [N_INPUT-1:0]      in_q;
  logic [DSTW-1:0]         j_q;
  logic                    done_q, done_d;

  logic [WIDTH-1:0]        thr_q, leak_q, rlen_q;
  logic signed [WIDTH-1:0] vmax_q, vmin_q;

  logic signed [WIDTH-1:0] v_cur, vc;
  logic [WIDTH-1:0]        r_cur;
  logic signed [AW-1:0]    acc, clamp;
  logic signed [AW-1:0]    vmin_x, vmax_x, thr_x;
  logic                    fire, refr_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.step) state_d = EVAL;
      EVAL:    if (j_q == LAST) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.net_reset) state_d = IDLE;
  end

  always_comb begin
    bus.busy = (state_q != IDLE);
    done_d   = (state_q == COMMIT) && !bus.net_reset;
  end

  // Datapath for neuron j_q; wide accumulator cannot overflow.
  always_comb begin
    v_cur = '0;
    r_cur = '0;
    for (int n = 0; n < N_OUTPUT; n++) begin
      if (j_q == DSTW'(n)) begin
        v_cur = v_q[n];
        r_cur = refr_q[n];
      end
    end
    acc = {{(AW-WIDTH){v_cur[WIDTH-1]}}, v_cur};
    for (int i = 0; i < N_INPUT; i++) begin
      for (int n = 0; n < N_OUTPUT; n++) begin
        if (in_q[i] && j_q == DSTW'(n))
          acc = acc + {{(AW-WIDTH){w_q[i][n][WIDTH-1]}}, w_q[i][n]};
      end
    end
    acc    = acc - {{(AW-WIDTH){1'b0}}, leak_q};
    vmin_x = {{(AW-WIDTH){vmin_q[WIDTH-1]}}, vmin_q};
    vmax_x = {{(AW-WIDTH){vmax_q[WIDTH-1]}}, vmax_q};
    thr_x  = {{(AW-WIDTH){1'b0}}, thr_q};
    clamp  = acc;
    if (clamp < vmin_x) clamp = vmin_x;
    if (clamp > vmax_x) clamp = vmax_x;
    vc        = clamp[WIDTH-1:0];
    fire      = (clamp >= thr_x);
    refr_busy = (r_cur != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_INPUT; i++)
        for (int n = 0; n < N_OUTPUT; n++)
          w_q[i][n] <= '0;
      for (int n = 0; n < N_OUTPUT; n++) begin
        v_q[n]    <= '0;
        refr_q[n] <= '0;
      end
      shadow_q <= '0;
      spike_q  <= '0;
      in_q     <= '0;
      j_q      <= '0;
      done_q   <= 1'b0;
      thr_q    <= '1;
      leak_q   <= '0;
      rlen_q   <= '0;
      vmax_q   <= {1'b0, {(WIDTH-1){1'b1}}};
      vmin_q   <= {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      if (bus.load_params) begin
        thr_q  <= bus.param_threshold;
        leak_q <= bus.param_leak;
        rlen_q <= bus.param_refr;
        vmax_q <= bus.param_vmax;
        vmin_q <= bus.param_vmin;
      end
      for (int i = 0; i < N_INPUT; i++)
        for (int n = 0; n < N_OUTPUT; n++)
          if (bus.update_synapse &&
              bus.syn_src == SRCW'(i) &&
              bus.syn_dst == DSTW'(n))
            w_q[i][n] <= bus.syn_weight;
      if (bus.net_reset) begin
        for (int n = 0; n < N_OUTPUT; n++) begin
          v_q[n]    <= '0;
          refr_q[n] <= '0;
        end
        shadow_q <= '0;
        spike_q  <= '0;
      end else begin
        if (state_q == EVAL) begin
          for (int n = 0; n < N_OUTPUT; n++) begin
            if (j_q == DSTW'(n)) begin
              if (refr_busy) begin
                refr_q[n]   <= r_cur - WIDTH'(1);
                v_q[n]      <= '0;
                shadow_q[n] <= 1'b0;
              end else if (fire) begin
                refr_q[n]   <= rlen_q;
                v_q[n]      <= '0;
                shadow_q[n] <= 1'b1;
              end else begin
                v_q[n]      <= vc;
                shadow_q[n] <= 1'b0;
              end
            end
          end
        end
        if (state_q == COMMIT) spike_q <= shadow_q;
      end
      if (state_q == IDLE && bus.step) begin
        in_q <= bus.spike_in;
        j_q  <= '0;
      end else if (state_q == EVAL) begin
        j_q <= j_q + 1'b1;
      end
      done_q <= done_d;
    end
  end

  always_comb begin
    bus.done     = done_q;
    bus.dbg_vmem = '0;
    for (int n = 0; n < N_OUTPUT; n++) begin
      bus.spike_out[n] = spike_q[n];
      if (bus.dbg_sel == DSTW'(n)) bus.dbg_vmem = v_q[n];
    end
  end
endmodule

// File: tb/tb_snn_lif_core.sv
// Directed bench for snn_lif_core: integration, refractory,
// clamping, busy rules, net_reset abort and async reset.
module tb_snn_lif_core;
  localparam int W  = 16;
  localparam int NI = 4;
  localparam int NO = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  snn_lif_if #(.WIDTH(W), .N_INPUT(NI), .N_OUTPUT(NO)) bus ();

  snn_lif_core #(.WIDTH(W), .N_INPUT(NI), .N_OUTPUT(NO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int nvec = 0;
  int nerr = 0;

  function automatic logic [2:0] spk();
    return {bus.spike_out[2], bus.spike_out[1], bus.spike_out[0]};
  endfunction

  task automatic idle_inputs();
    bus.param_threshold = '0;
    bus.param_leak      = '0;
    bus.param_refr      = '0;
    bus.param_vmax      = '0;
    bus.param_vmin      = '0;
    bus.load_params     = 1'b0;
    bus.syn_src         = '0;
    bus.syn_dst         = '0;
    bus.syn_weight      = '0;
    bus.update_synapse  = 1'b0;
    bus.net_reset       = 1'b0;
    bus.spike_in        = '0;
    bus.step            = 1'b0;
    bus.dbg_sel         = '0;
  endtask

  task automatic load(input int thr, input int lk, input int rf,
                      input int vmax, input int vmin);
    bus.param_threshold = W'(thr);
    bus.param_leak      = W'(lk);
    bus.param_refr      = W'(rf);
    bus.param_vmax      = W'(vmax);
    bus.param_vmin      = W'(vmin);
    bus.load_params     = 1'b1;
    @(negedge clk);
    bus.load_params     = 1'b0;
  endtask

  task automatic write_w(input int s, input int d, input int wt);
    bus.syn_src        = 2'(s);
    bus.syn_dst        = 2'(d);
    bus.syn_weight     = W'(wt);
    bus.update_synapse = 1'b1;
    @(negedge clk);
    bus.update_synapse = 1'b0;
  endtask

  task automatic nreset();
    bus.net_reset = 1'b1;
    @(negedge clk);
    bus.net_reset = 1'b0;
  endtask

  // Latency counted in cycles from the step edge; 99 means timeout.
  task automatic run_step(input logic [3:0] sin, output int lat);
    bus.spike_in = sin;
    bus.step     = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    lat = 99;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic get_v(input int n, output int v);
    bus.dbg_sel = 2'(n);
    #1;
    v = int'(bus.dbg_vmem);
  endtask

  task automatic test_reset();
    int v, lat;
    nvec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      $display("FAIL reset_ctl busy=%b done=%b want 0/0", bus.busy, bus.done);
      nerr++;
    end
    nvec++;
    if (spk() !== 3'b000) begin
      $display("FAIL reset_spk got %b want 000", spk());
      nerr++;
    end
    for (int n = 0; n < NO; n++) begin
      get_v(n, v);
      nvec++;
      if (v !== 0) begin
        $display("FAIL reset_v%0d got %0d want 0", n, v);
        nerr++;
      end
    end
    run_step(4'b0000, lat);
    nvec++;
    if (lat !== 4) begin
      $display("FAIL step_latency got %0d want 4", lat);
      nerr++;
    end
    nvec++;
    if (spk() !== 3'b000) begin
      $display("FAIL idle_step_spk got %b want 000", spk());
      nerr++;
    end
    @(negedge clk);
    nvec++;
    if (bus.done !== 1'b0) begin
      $display("FAIL done_pulse got %b want 0", bus.done);
      nerr++;
    end
    for (int n = 0; n < NO; n++) begin
      get_v(n, v);
      nvec++;
      if (v !== 0) begin
        $display("FAIL idle_step_v%0d got %0d want 0", n, v);
        nerr++;
      end
    end
  endtask

  task automatic test_integrate();
    int v, lat;
    logic ev_s [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
    int   ev_v [8] = '{500, 0, 0, 0, 0, 0, 0, 500};
    nreset();
    load(1000, 100, 5, 32767, -32768);
    write_w(0, 0, 600);
    for (int s = 0; s < 8; s++) begin
      run_step(4'b0001, lat);
      get_v(0, v);
      nvec++;
      if (lat !== 4 || bus.spike_out[0] !== ev_s[s] || v !== ev_v[s]) begin
        $display("FAIL integ_step%0d lat=%0d spk0=%b v0=%0d want 4/%b/%0d",
                 s + 1, lat, bus.spike_out[0], v, ev_s[s], ev_v[s]);
        nerr++;
      end
    end
  endtask

  task automatic test_clamp();
    int v, lat;
    int ev [3] = '{-110, -150, -150};
    nreset();
    load(1000, 100, 5, 32767, -150);
    write_w(1, 2, -10);
    for (int s = 0; s < 3; s++) begin
      run_step(4'b0010, lat);
      get_v(2, v);
      nvec++;
      if (v !== ev[s] || bus.spike_out[2] !== 1'b0) begin
        $display("FAIL clamp_step%0d v2=%0d spk2=%b want %0d/0",
                 s + 1, v, bus.spike_out[2], ev[s]);
        nerr++;
      end
    end
  endtask

  task automatic test_busy();
    int v, dones, lat;
    nreset();
    load(1000, 100, 5, 32767, -32768);
    bus.spike_in = 4'b0001;
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    nvec++;
    if (bus.busy !== 1'b1) begin
      $display("FAIL busy_set got %b want 1", bus.busy);
      nerr++;
    end
    @(negedge clk);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    nvec++;
    if (dones !== 1) begin
      $display("FAIL ignored_step dones=%0d want 1", dones);
      nerr++;
    end
    get_v(0, v);
    nvec++;
    if (v !== 500) begin
      $display("FAIL ignored_step_v0 got %0d want 500", v);
      nerr++;
    end
    nreset();
    bus.spike_in = 4'b0001;
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    bus.syn_src = 2'd0;
    bus.syn_dst = 2'd2;
    bus.syn_weight = 16'sd2000;
    bus.update_synapse = 1'b1;
    @(negedge clk);
    bus.update_synapse = 1'b0;
    lat = 99;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    nvec++;
    if (lat !== 4 || spk() !== 3'b100) begin
      $display("FAIL midstep_syn lat=%0d spk=%b want 4/100", lat, spk());
      nerr++;
    end
    get_v(1, v);
    nvec++;
    if (v !== -100) begin
      $display("FAIL midstep_v1 got %0d want -100", v);
      nerr++;
    end
  endtask

  task automatic test_net_reset();
    int v, dones, lat;
    bus.spike_in = 4'b0000;
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    @(negedge clk);
    get_v(0, v);
    nvec++;
    if (v !== 400) begin
      $display("FAIL abort_pre_v0 got %0d want 400", v);
      nerr++;
    end
    bus.net_reset = 1'b1;
    @(negedge clk);
    bus.net_reset = 1'b0;
    get_v(0, v);
    nvec++;
    if (bus.busy !== 1'b0 || spk() !== 3'b000 || v !== 0) begin
      $display("FAIL abort busy=%b spk=%b v0=%0d want 0/000/0",
               bus.busy, spk(), v);
      nerr++;
    end
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    nvec++;
    if (dones !== 0) begin
      $display("FAIL abort_done dones=%0d want 0", dones);
      nerr++;
    end
    run_step(4'b0001, lat);
    get_v(0, v);
    nvec++;
    if (lat !== 4 || v !== 500 || spk() !== 3'b100) begin
      $display("FAIL after_abort lat=%0d v0=%0d spk=%b want 4/500/100",
               lat, v, spk());
      nerr++;
    end
  endtask

  task automatic test_async_reset();
    int v, lat;
    bus.spike_in = 4'b0001;
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    nvec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || spk() !== 3'b000) begin
      $display("FAIL async_rst busy=%b done=%b spk=%b want 0/0/000",
               bus.busy, bus.done, spk());
      nerr++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_step(4'b0001, lat);
    get_v(0, v);
    nvec++;
    if (lat !== 4 || v !== 0 || spk() !== 3'b000) begin
      $display("FAIL post_rst lat=%0d v0=%0d spk=%b want 4/0/000",
               lat, v, spk());
      nerr++;
    end
  endtask

  task automatic test_vmax();
    int v, lat;
    load(65535, 0, 0, 700, -32768);
    write_w(0, 0, 600);
    run_step(4'b0001, lat);
    get_v(0, v);
    nvec++;
    if (v !== 600) begin
      $display("FAIL vmax_step1 got %0d want 600", v);
      nerr++;
    end
    run_step(4'b0001, lat);
    get_v(0, v);
    nvec++;
    if (v !== 700 || bus.spike_out[0] !== 1'b0) begin
      $display("FAIL vmax_step2 v0=%0d spk0=%b want 700/0",
               v, bus.spike_out[0]);
      nerr++;
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_integrate();
    test_clamp();
    test_busy();
    test_net_reset();
    test_async_reset();
    test_vmax();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
